// File: rtl/enc8b10b_seq.sv
// Byte-to-symbol sequencer for the 8b/10b encoder: one-deep output register,
// ABCD classification, running-disparity tracking and idle comma insertion.
module enc8b10b_seq #(
  parameter logic [7:0] IDLE_K = 8'hBC,
  parameter int         CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_k,
  input  logic             idle_en,
  input  logic             rd_load,
  input  logic             rd_load_val,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_data5,
  output logic [2:0]       out_data3,
  output logic [5:0]       out_L,
  output logic             out_compls6,
  output logic             out_compls4,
  output logic             out_alt7,
  output logic             out_idle,
  output logic             out_k_err,
  output logic             rd_cur,
  output logic [CNT_W-1:0] sym_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic       slot_free, load, k_legal;
  logic [7:0] src;
  logic       src_k, src_idle, src_err;
  logic       bit_a, bit_b, bit_c, bit_d, bit_e, bit_f, bit_g, bit_h;
  logic       l40, l31, l22, l13, l04;
  logic       rd_use, rd6, rd_next;
  logic       pd1s6, nd1s6, nd0s6, pd0s6, nd1s4, pd1s4, nd0s4, pd0s4;
  logic       compls6, compls4, alt7;

  assign slot_free = ~out_valid | out_ready;
  assign in_ready  = slot_free & ~reset;
  assign load      = slot_free & (in_valid | idle_en);

  assign k_legal = (in_data[4:0] == 5'b11100) || (in_data == 8'hF7) ||
                   (in_data == 8'hFB) || (in_data == 8'hFD) || (in_data == 8'hFE);

  // Illegal K codes are replaced by the idle comma but still count as data.
  always_comb begin
    src      = IDLE_K;
    src_k    = 1'b1;
    src_idle = 1'b1;
    src_err  = 1'b0;
    if (in_valid) begin
      src_idle = 1'b0;
      if (in_k && !k_legal) begin
        src_err = 1'b1;
      end else begin
        src   = in_data;
        src_k = in_k;
      end
    end
  end

  assign {bit_h, bit_g, bit_f, bit_e, bit_d, bit_c, bit_b, bit_a} = src;

  always_comb begin
    l40 = ($countones(src[3:0]) == 4);
    l31 = ($countones(src[3:0]) == 3);
    l22 = ($countones(src[3:0]) == 2);
    l13 = ($countones(src[3:0]) == 1);
    l04 = ($countones(src[3:0]) == 0);
  end

  // A forced RD applies to the symbol loaded in the same cycle.
  assign rd_use = rd_load ? rd_load_val : rd_cur;

  always_comb begin
    pd1s6   = (bit_e & bit_d & ~bit_c & ~bit_b & ~bit_a) | (~bit_e & ~l22 & ~l31);
    nd1s6   = src_k | (bit_e & ~l22 & ~l13) | (~bit_e & ~bit_d & bit_c & bit_b & bit_a);
    nd0s6   = pd1s6;
    pd0s6   = src_k | (bit_e & ~l22 & ~l13);
    compls6 = (pd1s6 & ~rd_use) | (nd1s6 & rd_use);
    rd6     = rd_use ^ (nd0s6 | pd0s6);
    nd1s4   = bit_f & bit_g;
    pd1s4   = (~bit_f & ~bit_g) | (src_k & (bit_f ^ bit_g));
    nd0s4   = ~bit_f & ~bit_g;
    pd0s4   = bit_f & bit_g & bit_h;
    compls4 = (pd1s4 & ~rd6) | (nd1s4 & rd6);
    rd_next = rd6 ^ (nd0s4 | pd0s4);
    alt7    = bit_f & bit_g & bit_h &
              (src_k | (rd_use ? (~bit_e & bit_d & l31) : (bit_e & ~bit_d & l13)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_data5   <= '0;
      out_data3   <= '0;
      out_L       <= '0;
      out_compls6 <= 1'b0;
      out_compls4 <= 1'b0;
      out_alt7    <= 1'b0;
      out_idle    <= 1'b0;
      out_k_err   <= 1'b0;
      rd_cur      <= 1'b0;
      sym_count   <= '0;
    end else if (load) begin
      out_valid   <= 1'b1;
      out_data5   <= src[4:0];
      out_data3   <= src[7:5];
      out_L       <= {l40, l31, l22, l13, l04, src_k};
      out_compls6 <= compls6;
      out_compls4 <= compls4;
      out_alt7    <= alt7;
      out_idle    <= src_idle;
      out_k_err   <= src_err;
      rd_cur      <= rd_next;
      sym_count   <= sym_count + CNT_ONE;
    end else begin
      if (slot_free) begin
        out_valid <= 1'b0;
      end
      if (rd_load) begin
        rd_cur <= rd_load_val;
      end
    end
  end

endmodule

// File: tb/tb_enc8b10b_seq.sv
// Directed bench for enc8b10b_seq: idle commas, disparity/complement control,
// alt7, stalls, illegal K replacement, RD forcing and counter wrap.
module tb_enc8b10b_seq;

  logic       clk = 1'b0;
  logic       reset, in_valid, in_k, idle_en, rd_load, rd_load_val, out_ready;
  logic [7:0] in_data;
  logic       in_ready, out_valid, out_compls6, out_compls4, out_alt7;
  logic       out_idle, out_k_err, rd_cur;
  logic [4:0] out_data5;
  logic [2:0] out_data3;
  logic [5:0] out_L;
  logic [3:0] sym_count;
  logic [6:0] flags;
  logic [3:0] exp_cnt;
  logic       exp_rd, c;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  enc8b10b_seq #(.IDLE_K(8'hBC), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_k(in_k), .idle_en(idle_en), .rd_load(rd_load),
    .rd_load_val(rd_load_val), .out_valid(out_valid), .out_ready(out_ready),
    .out_data5(out_data5), .out_data3(out_data3), .out_L(out_L),
    .out_compls6(out_compls6), .out_compls4(out_compls4), .out_alt7(out_alt7),
    .out_idle(out_idle), .out_k_err(out_k_err), .rd_cur(rd_cur),
    .sym_count(sym_count)
  );

  // {valid, idle, k_err, compls6, compls4, alt7, rd_cur}
  assign flags = {out_valid, out_idle, out_k_err, out_compls6, out_compls4, out_alt7, rd_cur};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_data = 8'h00; in_k = 1'b0;
    idle_en = 1'b1; out_ready = 1'b1; rd_load = 1'b0; rd_load_val = 1'b0;
    tick(); tick();
    checks++;
    if (flags !== 7'b0) begin
      errors++; $display("FAIL reset_flags got %b exp %b", flags, 7'b0);
    end
    checks++;
    if ({out_data5, out_data3, out_L, sym_count} !== 18'h0) begin
      errors++; $display("FAIL reset_data got %h exp 0", {out_data5, out_data3, out_L, sym_count});
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready);
    end
    exp_cnt = 4'd0;
  endtask

  task automatic test_idle_stream();
    in_valid = 1'b0;
    reset = 1'b0;
    exp_rd = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_cnt = exp_cnt + 4'd1;
      c = exp_rd;
      checks++;
      if (flags !== {1'b1, 1'b1, 1'b0, c, c, 1'b0, ~exp_rd}) begin
        errors++; $display("FAIL idle_flags[%0d] got %b exp %b", i, flags, {1'b1, 1'b1, 1'b0, c, c, 1'b0, ~exp_rd});
      end
      checks++;
      if ({out_data5, out_data3, out_L} !== {5'b11100, 3'b101, 6'b001001}) begin
        errors++; $display("FAIL idle_sym[%0d] got %b exp %b", i, {out_data5, out_data3, out_L}, {5'b11100, 3'b101, 6'b001001});
      end
      checks++;
      if (sym_count !== exp_cnt) begin
        errors++; $display("FAIL idle_cnt[%0d] got %0d exp %0d", i, sym_count, exp_cnt);
      end
      exp_rd = ~exp_rd;
    end
  endtask

  task automatic test_d00();
    in_valid = 1'b1; in_data = 8'h00; in_k = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_cnt = exp_cnt + 4'd1;
      // D0 at RD- complements the 6b block; its 4b block stays, RD stays negative
      checks++;
      if (flags !== 7'b1001000) begin
        errors++; $display("FAIL d00_flags[%0d] got %b exp %b", i, flags, 7'b1001000);
      end
      checks++;
      if ({out_data5, out_data3, out_L} !== {5'b00000, 3'b000, 6'b000010}) begin
        errors++; $display("FAIL d00_sym[%0d] got %b exp %b", i, {out_data5, out_data3, out_L}, {5'b00000, 3'b000, 6'b000010});
      end
    end
    checks++;
    if (sym_count !== exp_cnt) begin
      errors++; $display("FAIL d00_cnt got %0d exp %0d", sym_count, exp_cnt);
    end
  endtask

  task automatic test_alt7();
    logic [7:0] bytes [4]  = '{8'hE7, 8'hF7, 8'hE7, 8'hF1};
    logic [6:0] expf  [4]  = '{7'b1000001, 7'b1001001, 7'b1001100, 7'b1000011};
    logic [5:0] expl  [4]  = '{6'b010000, 6'b010000, 6'b010000, 6'b000100};
    for (int i = 0; i < 4; i++) begin
      in_data = bytes[i];
      tick();
      exp_cnt = exp_cnt + 4'd1;
      checks++;
      if (flags !== expf[i]) begin
        errors++; $display("FAIL alt7_flags[%0d] got %b exp %b", i, flags, expf[i]);
      end
      checks++;
      if ({out_data3, out_data5, out_L} !== {bytes[i], expl[i]}) begin
        errors++; $display("FAIL alt7_sym[%0d] got %b exp %b", i, {out_data3, out_data5, out_L}, {bytes[i], expl[i]});
      end
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    in_data = 8'h3A;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (in_ready !== 1'b0) begin
        errors++; $display("FAIL stall_in_ready[%0d] got %b exp 0", i, in_ready);
      end
      tick();
      checks++;
      if ({flags, out_data3, out_data5, sym_count} !== {7'b1000011, 8'hF1, exp_cnt}) begin
        errors++; $display("FAIL stall_hold[%0d] got %h exp %h", i, {flags, out_data3, out_data5, sym_count}, {7'b1000011, 8'hF1, exp_cnt});
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL stall_release_ready got %b exp 1", in_ready);
    end
    tick();
    exp_cnt = exp_cnt + 4'd1;
    checks++;
    if ({out_data3, out_data5, out_valid, sym_count} !== {8'h3A, 1'b1, exp_cnt}) begin
      errors++; $display("FAIL stall_release_sym got %h exp %h", {out_data3, out_data5, out_valid, sym_count}, {8'h3A, 1'b1, exp_cnt});
    end
  endtask

  task automatic test_k_codes();
    in_k = 1'b1; in_data = 8'h55;
    tick();
    exp_cnt = exp_cnt + 4'd1;
    checks++;
    if ({out_valid, out_idle, out_k_err, out_data5, out_data3, out_L} !== {3'b101, 5'b11100, 3'b101, 6'b001001}) begin
      errors++; $display("FAIL kerr_sym got %b exp %b", {out_valid, out_idle, out_k_err, out_data5, out_data3, out_L}, {3'b101, 5'b11100, 3'b101, 6'b001001});
    end
    in_data = 8'hFB;
    tick();
    exp_cnt = exp_cnt + 4'd1;
    checks++;
    if ({out_valid, out_idle, out_k_err, out_data5, out_data3, out_L} !== {3'b100, 5'b11011, 3'b111, 6'b010001}) begin
      errors++; $display("FAIL klegal_sym got %b exp %b", {out_valid, out_idle, out_k_err, out_data5, out_data3, out_L}, {3'b100, 5'b11011, 3'b111, 6'b010001});
    end
    in_k = 1'b0;
  endtask

  task automatic test_rd_load();
    in_valid = 1'b0; idle_en = 1'b0; rd_load = 1'b1; rd_load_val = 1'b0;
    tick();
    checks++;
    if ({out_valid, rd_cur, sym_count} !== {2'b00, exp_cnt}) begin
      errors++; $display("FAIL rdload_noload got %b exp %b", {out_valid, rd_cur, sym_count}, {2'b00, exp_cnt});
    end
    rd_load_val = 1'b1; idle_en = 1'b1;
    tick();
    exp_cnt = exp_cnt + 4'd1;
    checks++;
    if (flags !== 7'b1101100) begin
      errors++; $display("FAIL rdload_k285 got %b exp %b", flags, 7'b1101100);
    end
    checks++;
    if (sym_count !== exp_cnt) begin
      errors++; $display("FAIL rdload_cnt_wrap got %0d exp %0d", sym_count, exp_cnt);
    end
    rd_load = 1'b0;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h00;
    tick();
    checks++;
    if ({flags, in_ready} !== {7'b1101100, 1'b0}) begin
      errors++; $display("FAIL mid_hold got %b exp %b", {flags, in_ready}, {7'b1101100, 1'b0});
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({flags, sym_count, in_ready} !== 12'h0) begin
      errors++; $display("FAIL mid_reset got %b exp 0", {flags, sym_count, in_ready});
    end
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    exp_cnt = 4'd0;
  endtask

  task automatic test_wrap();
    idle_en = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      tick();
      exp_cnt = exp_cnt + 4'd1;
      checks++;
      if (sym_count !== exp_cnt) begin
        errors++; $display("FAIL wrap_cnt[%0d] got %0d exp %0d", i, sym_count, exp_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_stream();
    test_d00();
    test_alt7();
    test_stall();
    test_k_codes();
    test_rd_load();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
